// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // True when the word index of addr lies beyond the instruction memory.
    // Only addr[31:2] matters; the byte offset never selects a word.
    function automatic logic word_out_of_range(input logic [29:0] word_idx,
                                               input logic [31:0] words);
        return {2'b00, word_idx} >= words;
    endfunction

endpackage

// File: rtl/fetch_next_pc_sel.sv
// Purpose: next-PC priority select (redirect > fault check > advance > hold) and illegal-target check.
// Latency: purely combinational, zero cycles.
// Backpressure: holds pc when the fetch slot is full and decode is not ready.
// Macro: FETCH_MISALIGN_TRAP_EN makes a redirect target with nonzero bits [1:0] illegal;
//        without it those bits are dropped on load.
// Ports: pc / redirect_valid / redirect_target / slot_free in;
//        next_pc, redirect_fault, pc_fault, capture out.
import fetch_pkg::*;

module next_pc_sel #(
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        slot_free,
    output logic [31:0] next_pc,
    output logic        redirect_fault,
    output logic        pc_fault,
    output logic        capture
);

    localparam logic [31:0] WORDS = IMEM_WORDS;

    logic [31:0] target_load;
    logic        target_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_load = redirect_target;
    assign target_bad  = (|redirect_target[1:0])
                       | word_out_of_range(redirect_target[31:2], WORDS);
`else
    // Byte offset is discarded so a misaligned target simply fetches its word.
    logic unused_align_bits;
    assign unused_align_bits = ^redirect_target[1:0];
    assign target_load = {redirect_target[31:2], 2'b00};
    assign target_bad  = word_out_of_range(redirect_target[31:2], WORDS);
`endif

    always_comb begin
        next_pc        = pc;
        redirect_fault = 1'b0;
        pc_fault       = 1'b0;
        capture        = 1'b0;
        if (redirect_valid) begin
            // An illegal target leaves pc alone; the fault path freezes it.
            if (target_bad) begin
                redirect_fault = 1'b1;
            end else begin
                next_pc = target_load;
            end
        end else if (slot_free) begin
            if (word_out_of_range(pc[31:2], WORDS)) begin
                pc_fault = 1'b1;
            end else begin
                capture = 1'b1;
                next_pc = pc + PC_STEP;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction-fetch stage; owns pc, fills a one-entry fetch slot, sticky fault on illegal fetch.
// Latency: instruction captured on the edge that advances pc; slot valid one cycle after pc presented.
// Backpressure: slot and pc hold while if_valid & !if_ready; redirects flush the slot.
// Macro: FETCH_MISALIGN_TRAP_EN (see next_pc_sel) enables faulting on misaligned redirect targets.
// Ports: clk/rst; pc out + inst_in in (combinational imem); redirect_valid/target in;
//        if_valid/if_pc/if_inst out, if_ready in; fault/fault_pc/fetch_count out.
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t state;

    logic        slot_free;
    logic [31:0] next_pc;
    logic        redirect_fault;
    logic        pc_fault;
    logic        capture;

    assign slot_free = !if_valid || if_ready;

    next_pc_sel #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_next_pc_sel (
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .slot_free       (slot_free),
        .next_pc         (next_pc),
        .redirect_fault  (redirect_fault),
        .pc_fault        (pc_fault),
        .capture         (capture)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            if_valid    <= 1'b0;
            if_pc       <= 32'h0;
            if_inst     <= NOP_INST;
            fault       <= 1'b0;
            fault_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            // Handshake is counted even when a redirect flushes the slot this edge.
            if (if_valid && if_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end

            case (state)
                RUN: begin
                    pc <= next_pc;
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                    end
                    if (redirect_fault) begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        fault_pc <= redirect_target;
                    end else if (pc_fault) begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        fault_pc <= pc;
                        if_valid <= 1'b0;
                    end else if (capture) begin
                        if_pc    <= pc;
                        if_inst  <= inst_in;
                        if_valid <= 1'b1;
                    end
                end
                FAULT: begin
                    // Sticky: pc frozen, redirects ignored, only rst leaves.
                    fault    <= 1'b1;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit with a 32-word combinational imem model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises if_ready stalls, redirects with same-cycle handshakes and fault paths.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [32];

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .IMEM_WORDS   (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .inst_in         (inst_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_ready        (if_ready),
        .fault           (fault),
        .fault_pc        (fault_pc),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign inst_in = (pc[31:7] == 25'd0) ? mem[pc[6:2]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Advance one rising edge; outputs are then sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] last_pc;
        logic        seen_fault;

        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0010_0293;
        mem[2] = 32'h0012_8293;

        rst             = 1'b1;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        tick();
        tick();

        // Reset state
        check("rst_pc",       pc,          32'h0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc",    if_pc,       32'h0);
        check("rst_if_inst",  if_inst,     32'h0000_0013);
        check("rst_fault",    {31'd0, fault}, 32'd0);
        check("rst_fault_pc", fault_pc,    32'h0);
        check("rst_count",    fetch_count, 32'h0);

        // First fetch after release
        rst = 1'b0;
        tick();
        check("first_pc",       pc,          32'h4);
        check("first_if_valid", {31'd0, if_valid}, 32'd1);
        check("first_if_pc",    if_pc,       32'h0);
        check("first_if_inst",  if_inst,     32'h0010_0293);
        check("first_count",    fetch_count, 32'h0);

        // One handshake, then stall 3 cycles on if_pc=0x4
        if_ready = 1'b1;
        tick();
        check("adv_if_pc", if_pc,       32'h4);
        check("adv_count", fetch_count, 32'd1);
        if_ready = 1'b0;
        tick();
        tick();
        tick();
        check("stall_pc",       pc,          32'h8);
        check("stall_if_pc",    if_pc,       32'h4);
        check("stall_if_inst",  if_inst,     32'h1000_0001);
        check("stall_if_valid", {31'd0, if_valid}, 32'd1);
        check("stall_count",    fetch_count, 32'd1);

        if_ready = 1'b1;
        tick();
        check("resume_if_pc",   if_pc,       32'h8);
        check("resume_if_inst", if_inst,     32'h0012_8293);
        check("resume_count",   fetch_count, 32'd2);
        check("resume_pc",      pc,          32'hC);

        // Redirect to 0x8 with same-cycle handshake
        redirect_valid  = 1'b1;
        redirect_target = 32'h8;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, if_valid}, 32'd0);
        check("redir_pc",          pc,          32'h8);
        check("redir_count",       fetch_count, 32'd3);
        tick();
        check("redir_if_valid", {31'd0, if_valid}, 32'd1);
        check("redir_if_pc",    if_pc,       32'h8);
        check("redir_if_inst",  if_inst,     32'h0012_8293);
        check("redir_count2",   fetch_count, 32'd3);

        // Misaligned redirect to 0x6 (handshake of slot 0x8 counted)
        redirect_valid  = 1'b1;
        redirect_target = 32'h6;
        tick();
        redirect_valid = 1'b0;
        check("mis_count",    fetch_count, 32'd4);
        check("mis_if_valid", {31'd0, if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault",    {31'd0, fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h6);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("mis_sticky_fault", {31'd0, fault}, 32'd1);
        check("mis_sticky_valid", {31'd0, if_valid}, 32'd0);
        check("mis_frozen_pc",    pc,          32'hC);
        check("mis_sticky_fpc",   fault_pc,    32'h6);
`else
        check("mis_pc", pc, 32'h4);
        tick();
        check("mis_if_valid2", {31'd0, if_valid}, 32'd1);
        check("mis_if_pc",     if_pc,  32'h4);
        check("mis_no_fault",  {31'd0, fault}, 32'd0);
`endif

        // Sequential run off the end of imem
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_ready   = 1'b1;
        last_pc    = 32'hFFFF_FFFF;
        seen_fault = 1'b0;
        for (int n = 0; n < 64 && !seen_fault; n++) begin
            tick();
            if (fault) begin
                seen_fault = 1'b1;
            end else if (if_valid) begin
                last_pc = if_pc;
            end
        end
        check("seq_fault",    {31'd0, seen_fault}, 32'd1);
        check("seq_fault_pc", fault_pc,    32'h80);
        check("seq_last_pc",  last_pc,     32'h7C);
        check("seq_if_valid", {31'd0, if_valid}, 32'd0);
        check("seq_count",    fetch_count, 32'd32);
        tick();
        check("seq_frozen_pc", pc, 32'h80);

        // Reset pulse while faulted
        rst = 1'b1;
        tick();
        check("frst_fault", {31'd0, fault}, 32'd0);
        check("frst_pc",    pc,          32'h0);
        check("frst_count", fetch_count, 32'd0);
        rst = 1'b0;
        tick();
        check("frst_if_valid", {31'd0, if_valid}, 32'd1);
        check("frst_if_pc",    if_pc,   32'h0);
        check("frst_if_inst",  if_inst, 32'h0010_0293);

        // Redirect past end of imem faults with the raw target
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("oor_fault",    {31'd0, fault}, 32'd1);
        check("oor_fault_pc", fault_pc,   32'h100);
        check("oor_pc",       pc,         32'h4);
        check("oor_count",    fetch_count, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
